lfm_pulse_scheduler: RTL

Sequences the LFM chirp datapath (phase accumulator, sine ROM, output register) into a train of radar pulses. On a start request it latches the pulse configuration and validates it. It then emits per-pulse start/stop strobes, a gate, and a pulse index, timed in system clocks from microsecond-valued settings, until the requested pulse count has elapsed. It sits between the configuration registers and the phase accumulator and owns all pulse timing.

---
 rtl/lfm_pulse_scheduler.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/lfm_pulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : lfm_pulse_scheduler
// Description : Turns a start request into a train of LFM radar pulses.
//               The pulse configuration is latched and checked when a
//               request is taken. The block then emits per-pulse start/stop
//               strobes, a pulse gate and a pulse index, timed in system
//               clocks from microsecond-valued settings.
// Ports       : CLK, RESET        - clock, synchronous active-high reset
//               T_IMPULSE [9:0]   - pulse width, us
//               T_PERIOD  [12:0]  - pulse repetition period, us
//               NUM_OF_IMP [4:0]  - pulses per train
//               SIGN_START_GEN    - rising edge requests a train
//               ABORT             - level, terminates a running train
//               SIGN_START_CALC   - strobe, first cycle of each pulse
//               SIGN_STOP_CALC    - strobe, first cycle after each pulse
//               IMP_ACTIVE        - high for every cycle of a pulse
//               IMP_INDEX [4:0]   - 0-based index of the current pulse
//               BUSY              - train in progress
//               DONE              - strobe, train completed normally
//               CFG_ERR           - strobe, request rejected
// Revision    : 1.0 - initial release
// ============================================================================
module lfm_pulse_scheduler #(
    parameter int CLK_PER_US = 500,
    parameter int CNT_W      = 24
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [9:0]  T_IMPULSE,
    input  logic [12:0] T_PERIOD,
    input  logic [4:0]  NUM_OF_IMP,
    input  logic        SIGN_START_GEN,
    input  logic        ABORT,
    output logic        SIGN_START_CALC,
    output logic        SIGN_STOP_CALC,
    output logic        IMP_ACTIVE,
    output logic [4:0]  IMP_INDEX,
    output logic        BUSY,
    output logic        DONE,
    output logic        CFG_ERR
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CHECK = 2'd1;
    localparam logic [1:0] c_PULSE = 2'd2;
    localparam logic [1:0] c_GAP   = 2'd3;

    logic [1:0]       r_state;
    logic             r_start_prev;
    logic [9:0]       r_t_imp;
    logic [12:0]      r_t_per;
    logic [4:0]       r_num;
    logic [CNT_W-1:0] r_imp_cyc;
    logic [CNT_W-1:0] r_per_cyc;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_index;
    logic             r_start_calc;
    logic             r_stop_calc;
    logic             r_imp_active;
    logic             r_busy;
    logic             r_done;
    logic             r_cfg_err;

    logic             w_start_edge;
    logic             w_cfg_bad;
    logic [CNT_W-1:0] w_imp_cyc;
    logic [CNT_W-1:0] w_per_cyc;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_period_end;

    assign w_start_edge = SIGN_START_GEN && !r_start_prev;
    assign w_cfg_bad    = (r_t_imp == 10'd0) || (r_num == 5'd0) ||
                          ({3'b000, r_t_imp} > r_t_per);
    // Products are taken from the latched settings so that the counter
    // compare path never sees a multiplier.
    assign w_imp_cyc    = CNT_W'(r_t_imp) * CNT_W'(CLK_PER_US);
    assign w_per_cyc    = CNT_W'(r_t_per) * CNT_W'(CLK_PER_US);
    assign w_cnt_inc    = r_cnt + CNT_W'(1);
    assign w_period_end = (r_cnt == r_per_cyc - CNT_W'(1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= c_IDLE;
            // Resetting to 1 means a level held high through reset is not
            // mistaken for a request.
            r_start_prev <= 1'b1;
            r_t_imp      <= '0;
            r_t_per      <= '0;
            r_num        <= '0;
            r_imp_cyc    <= '0;
            r_per_cyc    <= '0;
            r_cnt        <= '0;
            r_index      <= '0;
            r_start_calc <= 1'b0;
            r_stop_calc  <= 1'b0;
            r_imp_active <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_start_prev <= SIGN_START_GEN;
            r_start_calc <= 1'b0;
            r_stop_calc  <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (w_start_edge) begin
                        r_t_imp <= T_IMPULSE;
                        r_t_per <= T_PERIOD;
                        r_num   <= NUM_OF_IMP;
                        r_state <= c_CHECK;
                        r_busy  <= 1'b1;
                    end
                end

                c_CHECK: begin
                    if (ABORT) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_cfg_bad) begin
                        r_cfg_err <= 1'b1;
                        r_state   <= c_IDLE;
                        r_busy    <= 1'b0;
                    end else begin
                        r_imp_cyc    <= w_imp_cyc;
                        r_per_cyc    <= w_per_cyc;
                        r_cnt        <= '0;
                        r_index      <= '0;
                        r_state      <= c_PULSE;
                        r_start_calc <= 1'b1;
                        r_imp_active <= 1'b1;
                    end
                end

                c_PULSE, c_GAP: begin
                    if (ABORT) begin
                        // Close the gate cleanly if a pulse was in flight.
                        r_stop_calc  <= r_imp_active;
                        r_imp_active <= 1'b0;
                        r_index      <= '0;
                        r_cnt        <= '0;
                        r_state      <= c_IDLE;
                        r_busy       <= 1'b0;
                    end else if (w_period_end) begin
                        // With no gap the pulse ends exactly at the period
                        // boundary, so the stop strobe lands here.
                        if (r_imp_cyc == r_per_cyc) begin
                            r_stop_calc <= 1'b1;
                        end
                        r_cnt <= '0;
                        if (r_index == r_num - 5'd1) begin
                            r_done       <= 1'b1;
                            r_imp_active <= 1'b0;
                            r_index      <= '0;
                            r_state      <= c_IDLE;
                            r_busy       <= 1'b0;
                        end else begin
                            r_index      <= r_index + 5'd1;
                            r_start_calc <= 1'b1;
                            r_imp_active <= 1'b1;
                            r_state      <= c_PULSE;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == r_imp_cyc) begin
                            r_stop_calc  <= 1'b1;
                            r_imp_active <= 1'b0;
                            r_state      <= c_GAP;
                        end
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign SIGN_START_CALC = r_start_calc;
    assign SIGN_STOP_CALC  = r_stop_calc;
    assign IMP_ACTIVE      = r_imp_active;
    assign IMP_INDEX       = r_index;
    assign BUSY            = r_busy;
    assign DONE            = r_done;
    assign CFG_ERR         = r_cfg_err;

endmodule
`default_nettype wire
